dram_arbiter: RTL and testbench

- Shares the single cache-line DRAM wrapper between NUM_PORTS requesters, e.g. the rasteriser framebuffer writer and the display scanout reader.
- Sits in the sclk (MIG ui_clk) domain, directly in front of the DRAM wrapper's read and write request interface.
- Arbitration is round-robin. Each accepted request is latched, so a requester is released as soon as it is acknowledged.
- Writes are posted. Read data is returned later with a per-port valid pulse.

---
 rtl/dram_arbiter.sv | 138 +++++++++++++
 tb/tb_dram_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one cache-line DRAM wrapper between NUM_PORTS requesters.
// One operation is in flight at a time; writes are posted, reads return with a per-port rvalid pulse.
module dram_arbiter #(
    parameter int  NUM_PORTS = 2,
    parameter int  ADDR_BITS = 27,
    parameter int  LINE_BITS = 512,
    localparam int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic                           sclk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           port_req,
    input  logic [NUM_PORTS-1:0]           port_we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] port_addr,
    input  logic [NUM_PORTS*LINE_BITS-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]           port_ack,
    output logic [NUM_PORTS-1:0]           port_rvalid,
    output logic [LINE_BITS-1:0]           port_rdata,
    input  logic                           dram_read_ready,
    input  logic                           dram_write_ready,
    output logic                           dram_read_request,
    output logic                           dram_write_request,
    output logic [ADDR_BITS-1:0]           dram_address,
    output logic [LINE_BITS-1:0]           dram_write_data,
    input  logic                           dram_read_response,
    input  logic [LINE_BITS-1:0]           dram_read_data,
    output logic                           busy,
    output logic [PORT_BITS-1:0]           owner
);

    // Handshake: a port holds req and its fields stable until it sees a one-cycle ack;
    // the ack means the request has been latched and the port may move on next cycle.
    typedef enum logic [1:0] {IDLE, ISSUE, W_DRAIN, R_WAIT} state_t;

    state_t                 state;
    logic [PORT_BITS-1:0]   rr_ptr;
    logic                   op_we;

    logic                   found;
    logic [PORT_BITS-1:0]   winner;
    logic [PORT_BITS-1:0]   next_ptr;
    logic                   sel_we;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [LINE_BITS-1:0]   sel_wdata;
    logic                   grant;

    // Two passes: first ports at or above rr_ptr, then wrap around from port 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && port_req[j] && (PORT_BITS'(j) >= rr_ptr)) begin
                found  = 1'b1;
                winner = PORT_BITS'(j);
            end
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && port_req[j]) begin
                found  = 1'b1;
                winner = PORT_BITS'(j);
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (winner == PORT_BITS'(j)) begin
                sel_we    = port_we[j];
                sel_addr  = port_addr[j*ADDR_BITS +: ADDR_BITS];
                sel_wdata = port_wdata[j*LINE_BITS +: LINE_BITS];
            end
        end
    end

    assign next_ptr = (winner == PORT_BITS'(NUM_PORTS - 1)) ? '0 : winner + PORT_BITS'(1);

    // Wrapper readiness depends combinationally on our requests, so it only gates the
    // latch decision; the requests themselves come straight from flops.
    assign grant = (state == IDLE) && dram_read_ready && dram_write_ready && found;

    assign busy = (state != IDLE);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            op_we              <= 1'b0;
            owner              <= '0;
            port_ack           <= '0;
            port_rvalid        <= '0;
            port_rdata         <= '0;
            dram_read_request  <= 1'b0;
            dram_write_request <= 1'b0;
            dram_address       <= '0;
            dram_write_data    <= '0;
        end else begin
            port_ack           <= '0;
            port_rvalid        <= '0;
            dram_read_request  <= 1'b0;
            dram_write_request <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner              <= winner;
                        op_we              <= sel_we;
                        dram_address       <= sel_addr;
                        dram_write_data    <= sel_wdata;
                        port_ack           <= NUM_PORTS'(1) << winner;
                        dram_write_request <= sel_we;
                        dram_read_request  <= ~sel_we;
                        rr_ptr             <= next_ptr;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= op_we ? W_DRAIN : R_WAIT;
                end
                // Address and data stay put here: the wrapper reads them during its burst.
                W_DRAIN: begin
                    if (dram_write_ready) begin
                        state <= IDLE;
                    end
                end
                R_WAIT: begin
                    if (dram_read_response) begin
                        port_rdata  <= dram_read_data;
                        port_rvalid <= NUM_PORTS'(1) << owner;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboarded bench for dram_arbiter: directed requests push expected grants/read returns,
// a monitor pops and compares them, and a small wrapper model plays the DRAM side.
module tb_dram_arbiter;

    localparam int NP     = 2;
    localparam int AB     = 27;
    localparam int LB     = 512;
    localparam int CTL_W  = NP + 1 + 1 + 1 + AB;
    localparam int EXP_W  = CTL_W + LB;
    localparam int RV_W   = NP + LB;
    localparam int WR_LAT = 8;
    localparam int RD_LAT = 20;

    logic             sclk;
    logic             rst_n;
    logic [NP-1:0]    port_req;
    logic [NP-1:0]    port_we;
    logic [NP*AB-1:0] port_addr;
    logic [NP*LB-1:0] port_wdata;
    logic [NP-1:0]    port_ack;
    logic [NP-1:0]    port_rvalid;
    logic [LB-1:0]    port_rdata;
    logic             dram_read_ready;
    logic             dram_write_ready;
    logic             dram_read_request;
    logic             dram_write_request;
    logic [AB-1:0]    dram_address;
    logic [LB-1:0]    dram_write_data;
    logic             dram_read_response;
    logic [LB-1:0]    dram_read_data;
    logic             busy;
    logic             owner;

    logic             mdl_ready;
    logic             mdl_resp;
    logic             spur_resp;
    logic             force_low;

    logic [EXP_W-1:0] ack_q[$];
    logic [RV_W-1:0]  rv_q[$];

    int checks;
    int errors;
    int cyc;
    int ack_seen;
    int rd_req_cyc;
    int wr_done_cyc;

    assign dram_read_ready    = mdl_ready & ~force_low;
    assign dram_write_ready   = mdl_ready & ~force_low;
    assign dram_read_response = mdl_resp | spur_resp;

    dram_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .LINE_BITS(LB)) dut (
        .sclk               (sclk),
        .rst_n              (rst_n),
        .port_req           (port_req),
        .port_we            (port_we),
        .port_addr          (port_addr),
        .port_wdata         (port_wdata),
        .port_ack           (port_ack),
        .port_rvalid        (port_rvalid),
        .port_rdata         (port_rdata),
        .dram_read_ready    (dram_read_ready),
        .dram_write_ready   (dram_write_ready),
        .dram_read_request  (dram_read_request),
        .dram_write_request (dram_write_request),
        .dram_address       (dram_address),
        .dram_write_data    (dram_write_data),
        .dram_read_response (dram_read_response),
        .dram_read_data     (dram_read_data),
        .busy               (busy),
        .owner              (owner)
    );

    // Clock and cycle counter
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge sclk);
            cyc++;
        end
    end

    function automatic logic [LB-1:0] rd_pat(input logic [AB-1:0] a);
        return {16{5'b10110, a}};
    endfunction

    function automatic logic [EXP_W-1:0] ack_exp(input int p, input logic we,
                                                 input logic [AB-1:0] a, input logic [LB-1:0] d);
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        return {oh, 1'(p), we, ~we, a, d};
    endfunction

    function automatic logic [RV_W-1:0] rv_exp(input int p, input logic [AB-1:0] a);
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        return {oh, rd_pat(a)};
    endfunction

    task automatic chk(input string name, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"},    EXP_W'(port_ack), '0);
        chk({tag, "_rvalid"}, EXP_W'(port_rvalid), '0);
        chk({tag, "_dreq"},   EXP_W'({dram_read_request, dram_write_request}), '0);
        chk({tag, "_addr"},   EXP_W'(dram_address), '0);
        chk({tag, "_wdata"},  EXP_W'(dram_write_data), '0);
        chk({tag, "_rdata"},  EXP_W'(port_rdata), '0);
        chk({tag, "_busy_owner"}, EXP_W'({busy, owner}), '0);
    endtask

    // Wrapper model: ready drops while an op is in progress
    initial begin
        mdl_ready      = 1'b1;
        mdl_resp       = 1'b0;
        dram_read_data = '0;
        wr_done_cyc    = 0;
        forever begin
            @(posedge sclk);
            #1;
            if (dram_write_request) begin
                logic [AB-1:0] cap_a;
                logic [LB-1:0] cap_d;
                cap_a     = dram_address;
                cap_d     = dram_write_data;
                mdl_ready = 1'b0;
                repeat (WR_LAT) begin
                    @(posedge sclk);
                    #1;
                    chk("wdrain_addr_hold", EXP_W'(dram_address), EXP_W'(cap_a));
                    chk("wdrain_data_hold", EXP_W'(dram_write_data), EXP_W'(cap_d));
                end
                mdl_ready   = 1'b1;
                wr_done_cyc = cyc;
            end else if (dram_read_request) begin
                logic [AB-1:0] cap_a;
                cap_a     = dram_address;
                mdl_ready = 1'b0;
                repeat (RD_LAT - 1) @(posedge sclk);
                #1;
                mdl_resp       = 1'b1;
                dram_read_data = rd_pat(cap_a);
                @(posedge sclk);
                #1;
                mdl_resp  = 1'b0;
                mdl_ready = 1'b1;
            end
        end
    end

    // Monitor: every grant and every read return must match the head of its queue
    initial begin
        logic [EXP_W-1:0] e;
        logic [RV_W-1:0]  r;
        ack_seen   = 0;
        rd_req_cyc = 0;
        forever begin
            @(negedge sclk);
            if (port_ack != '0 || dram_write_request || dram_read_request) begin
                if (dram_read_request) rd_req_cyc = cyc;
                if (port_ack != '0) ack_seen++;
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: port_ack=%b wreq=%b rreq=%b, expected no grant",
                             port_ack, dram_write_request, dram_read_request);
                end else begin
                    e = ack_q.pop_front();
                    chk("grant_ctl", EXP_W'({port_ack, owner, dram_write_request, dram_read_request, dram_address}),
                        EXP_W'(e[EXP_W-1 -: CTL_W]));
                    chk("grant_wdata", EXP_W'(dram_write_data), EXP_W'(e[LB-1:0]));
                end
            end
            if (port_rvalid != '0) begin
                if (rv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: port_rvalid=%b, expected none", port_rvalid);
                end else begin
                    r = rv_q.pop_front();
                    chk("rvalid_port", EXP_W'(port_rvalid), EXP_W'(r[RV_W-1 -: NP]));
                    chk("rdata", EXP_W'(port_rdata), EXP_W'(r[LB-1:0]));
                end
            end
        end
    end

    task automatic request_op(input int p, input logic we, input logic [AB-1:0] a, input logic [LB-1:0] d);
        int n;
        port_we[p]                = we;
        port_addr[p*AB +: AB]     = a;
        port_wdata[p*LB +: LB]    = d;
        port_req[p]               = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge sclk);
            if (port_ack[p]) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port %0d got no ack, expected one within 300 cycles", p);
        end
        @(posedge sclk);
        #1;
        port_req[p] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 400 && (busy || !mdl_ready || rv_q.size() != 0)) begin
            @(negedge sclk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=%b pending_reads=%0d, expected idle", name, busy, rv_q.size());
        end else begin
            chk({name, "_busy"}, EXP_W'(busy), '0);
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_acks(input int target);
        int n;
        n = 0;
        while (n < 500 && ack_seen < target) begin
            @(negedge sclk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL acks_timeout: saw %0d acks, expected %0d", ack_seen, target);
        end
        @(posedge sclk);
        #1;
    endtask

    // Directed stimulus
    initial begin
        logic [LB-1:0] pat_a;
        logic [LB-1:0] pat_c;
        logic [LB-1:0] pat_d;
        logic [LB-1:0] pat_e;
        int base;
        int n;
        checks     = 0;
        errors     = 0;
        pat_a      = {16{32'hA5A5_0100}};
        pat_c      = {16{32'hC3C3_0400}};
        pat_d      = {16{32'hD00D_0300}};
        pat_e      = {16{32'hE1E1_0900}};
        port_req   = '0;
        port_we    = '0;
        port_addr  = '0;
        port_wdata = '0;
        spur_resp  = 1'b0;
        force_low  = 1'b0;
        rst_n      = 1'b1;
        #3 rst_n   = 1'b0;
        #4;
        check_all_zero("reset");
        @(posedge sclk);
        #1 rst_n = 1'b1;
        @(posedge sclk);
        #1;

        // Port 0 posted write: ack and write request one cycle later, for one cycle
        ack_q.push_back(ack_exp(0, 1'b1, 27'h0000100, pat_a));
        port_we[0]          = 1'b1;
        port_addr[0 +: AB]  = 27'h0000100;
        port_wdata[0 +: LB] = pat_a;
        port_req[0]         = 1'b1;
        @(posedge sclk);
        #1;
        chk("write_ack_latency", EXP_W'({port_ack, dram_write_request, dram_read_request}), EXP_W'(4'b0110));
        @(posedge sclk);
        #1;
        chk("write_req_one_cycle", EXP_W'({port_ack, dram_write_request, dram_read_request}), '0);
        port_req[0] = 1'b0;
        wait_idle("write0");

        // Port 1 read, returned 20 cycles later on port 1 only
        ack_q.push_back(ack_exp(1, 1'b0, 27'h0000200, '0));
        rv_q.push_back(rv_exp(1, 27'h0000200));
        request_op(1, 1'b0, 27'h0000200, '0);
        wait_idle("read1");

        // Both ports read continuously: grants alternate 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            ack_q.push_back(ack_exp(k % 2, 1'b0, (k % 2) ? 27'h0000700 : 27'h0000600, '0));
            rv_q.push_back(rv_exp(k % 2, (k % 2) ? 27'h0000700 : 27'h0000600));
        end
        base                 = ack_seen;
        port_we              = '0;
        port_addr[0 +: AB]   = 27'h0000600;
        port_addr[AB +: AB]  = 27'h0000700;
        port_wdata           = '0;
        port_req             = 2'b11;
        wait_acks(base + 6);
        port_req = '0;
        wait_idle("round_robin");

        // Lone requester is re-granted back to back
        for (int k = 0; k < 2; k++) begin
            ack_q.push_back(ack_exp(0, 1'b0, 27'h0000800, '0));
            rv_q.push_back(rv_exp(0, 27'h0000800));
        end
        base               = ack_seen;
        port_addr[0 +: AB] = 27'h0000800;
        port_req[0]        = 1'b1;
        wait_acks(base + 2);
        port_req[0] = 1'b0;
        wait_idle("single_requester");

        // Ready held low: no grant; ack one cycle after ready rises
        force_low           = 1'b1;
        port_we[0]          = 1'b1;
        port_addr[0 +: AB]  = 27'h0000400;
        port_wdata[0 +: LB] = pat_c;
        port_req[0]         = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge sclk);
            chk("ready_low_no_grant", EXP_W'({port_ack, dram_write_request, dram_read_request, busy}), '0);
        end
        @(posedge sclk);
        #1;
        ack_q.push_back(ack_exp(0, 1'b1, 27'h0000400, pat_c));
        force_low = 1'b0;
        @(posedge sclk);
        #1;
        chk("ready_rise_ack", EXP_W'(port_ack), EXP_W'(2'b01));
        @(posedge sclk);
        #1;
        port_req[0] = 1'b0;
        wait_idle("ready_low");

        // Spurious read response in IDLE is ignored
        spur_resp = 1'b1;
        @(posedge sclk);
        #1;
        spur_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sclk);
            chk("spurious_no_rvalid", EXP_W'({port_rvalid, busy}), '0);
        end

        // Simultaneous write (port 1, rr favours it) and read (port 0) to the same line
        rd_req_cyc  = 0;
        wr_done_cyc = 0;
        ack_q.push_back(ack_exp(1, 1'b1, 27'h0000300, pat_d));
        ack_q.push_back(ack_exp(0, 1'b0, 27'h0000300, '0));
        rv_q.push_back(rv_exp(0, 27'h0000300));
        @(posedge sclk);
        #1;
        fork
            request_op(1, 1'b1, 27'h0000300, pat_d);
            request_op(0, 1'b0, 27'h0000300, '0);
        join
        wait_idle("write_then_read");
        chk("read_after_write_done", EXP_W'(rd_req_cyc > wr_done_cyc && wr_done_cyc != 0), EXP_W'(1));

        // Reset in R_WAIT drops the read: outputs clear at once, no rvalid later
        ack_q.push_back(ack_exp(0, 1'b0, 27'h0000500, '0));
        request_op(0, 1'b0, 27'h0000500, '0);
        repeat (3) @(posedge sclk);
        #1;
        chk("rwait_busy", EXP_W'(busy), EXP_W'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_op_reset");
        @(posedge sclk);
        #1 rst_n = 1'b1;
        n = 0;
        while (n < 60 && !mdl_ready) begin
            @(negedge sclk);
            n++;
        end
        repeat (3) @(negedge sclk);
        chk("no_rvalid_after_reset", EXP_W'({port_rvalid, busy}), '0);

        // Round-robin pointer restarts at port 0 after reset
        ack_q.push_back(ack_exp(0, 1'b1, 27'h0000900, pat_e));
        ack_q.push_back(ack_exp(1, 1'b1, 27'h0000A00, pat_a));
        @(posedge sclk);
        #1;
        fork
            request_op(0, 1'b1, 27'h0000900, pat_e);
            request_op(1, 1'b1, 27'h0000A00, pat_a);
        join
        wait_idle("post_reset");

        chk("ack_queue_drained", EXP_W'(ack_q.size()), '0);
        chk("rvalid_queue_drained", EXP_W'(rv_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
